// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, default RAM depth, word-count width helper.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEPTH_WORDS_DEF = 128;

  // The count port needs one extra bit so that a full-depth count is
  // representable alongside the 0-means-full encoding.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int WCNT_W_DEF = count_width(DEPTH_WORDS_DEF);

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler with a 2-bit byte index.
// Latency: word_dat holds the full word the cycle after the 4th accepted byte.
// Backpressure: none; the parent only pulses byte_vld on an accepted byte.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   clr             synchronous clear of index and word
//   byte_vld        accept byte_dat this cycle
//   byte_dat        incoming byte
//   word_dat        assembled word register
//   done            high in the cycle the 4th byte of a word is accepted
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word_dat,
  output logic        done
);

  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;

  // Shifting in from the top means four bytes fully replace the word, with
  // the first byte landing in [7:0]; no clear is needed between words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else if (clr) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else if (byte_vld) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      word_q     <= {byte_dat, word_q[31:8]};
    end
  end

  assign word_dat = word_q;
  assign done     = byte_vld && (byte_idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction RAM.
// Latency: we_o one cycle after the 4th byte of a word; done_o one cycle later.
// Backpressure: byte_ready_o low outside LOAD/CHECK; valid gaps stall forever.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start_i           load request, honoured only in IDLE
//   word_count_i      words to load (0 = DEPTH_WORDS), sampled with start_i
//   byte_valid_i/byte_data_i/byte_ready_o   byte stream handshake
//   we_o/waddr_o/wdata_o                     RAM write port (zero unless writing)
//   cpu_stall_o       high whenever a load is in progress
//   done_o            one-cycle completion pulse
//   err_o             sticky checksum error
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to append an XOR
// checksum byte to each load; otherwise err_o is tied low.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_i,
  input  logic [$clog2(DEPTH_WORDS):0] word_count_i,
  input  logic                         byte_valid_i,
  input  logic [7:0]                   byte_data_i,
  output logic                         byte_ready_o,
  output logic                         we_o,
  output logic [31:0]                  waddr_o,
  output logic [31:0]                  wdata_o,
  output logic                         cpu_stall_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int WCNT_W = count_width(DEPTH_WORDS);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, last_idx_q, last_idx_d;
  logic             byte_fire, start_acc, load_fire, word_last, asm_done;
  logic [31:0]      asm_word;

  assign byte_fire = byte_valid_i && byte_ready_o;
  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign load_fire = byte_fire && (state_q == ST_LOAD);
  assign word_last = (word_idx_q == last_idx_q);

  word_assembler u_word_assembler (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (start_acc),
    .byte_vld (load_fire),
    .byte_dat (byte_data_i),
    .word_dat (asm_word),
    .done     (asm_done)
  );

  // Store the index of the final word rather than the count, so the index
  // never has to reach DEPTH_WORDS. Oversized counts clamp to a full load.
  always_comb begin
    if (word_count_i == '0 || word_count_i > WCNT_W'(DEPTH_WORDS)) begin
      last_idx_d = IDX_W'(DEPTH_WORDS - 1);
    end else begin
      last_idx_d = IDX_W'(word_count_i - WCNT_W'(1));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_LOAD;
      ST_LOAD:  if (asm_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (word_last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: if (byte_fire) state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs; the RAM port is forced to zero outside WRITE.
  always_comb begin
    byte_ready_o = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    we_o         = 1'b0;
    waddr_o      = 32'd0;
    wdata_o      = 32'd0;
    cpu_stall_o  = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
    if (state_q == ST_WRITE) begin
      we_o                 = 1'b1;
      waddr_o[IDX_W+1:2]   = word_idx_q;
      wdata_o              = asm_word;
    end
  end

  // Word counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx_q <= '0;
      last_idx_q <= '0;
    end else if (start_acc) begin
      word_idx_q <= '0;
      last_idx_q <= last_idx_d;
    end else if (state_q == ST_WRITE && !word_last) begin
      word_idx_q <= word_idx_q + IDX_W'(1);
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       err_q;
  logic       check_fire;

  assign check_fire = byte_fire && (state_q == ST_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 8'd0;
      err_q  <= 1'b0;
    end else if (start_acc) begin
      csum_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      if (load_fire) csum_q <= csum_q ^ byte_data_i;
      if (check_fire && (byte_data_i != csum_q)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
